scanner_link_arbiter: RTL and testbench
=======================================

// Module: scanner_link_arbiter
// PURPOSE
//  Shares one serial output link (clkOut/dataOut pair) between two scanner units.
//  - Arbitrates the two scanners round-robin.
//  - Latches the winner's command byte and optional data byte.
//  - Serialises the latched bytes as one framed, LSB-first bit stream with a gated bit clock.
//  - Sits between the scanner instances and the off-chip communication driver.
// PARAMETERS
//  CLK_DIV  4  clk cycles per serial bit; even, >=2
//  CMD_W    8  command field width (codes 2,3,4,7 used by scanners)
//  DATA_W   8  data field width
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       asynchronous, active-high reset
//  req         in   2       per-scanner transfer request, level, bit i = scanner i
//  has_data    in   2       scanner i frame carries a data field after the command
//  cmd0/cmd1   in   CMD_W   command byte of scanner 0/1, sampled at grant
//  data0/data1 in   DATA_W  data byte of scanner 0/1, sampled at grant
//  gnt         out  2       one-hot grant, held for the whole frame
//  done        out  2       one-cycle pulse to scanner i when its frame's last bit ends
//  busy        out  1       high in any state other than IDLE
//  ser_frame   out  1       high while frame bits are on ser_data
//  ser_clk     out  1       bit clock: low in first half of each bit period, high in second
//  ser_data    out  1       serial data, held stable for a full bit period
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; last_gnt=1, so scanner 0 wins the first tie.
//  - States:
//    - IDLE: if req != 0, pick a winner (details below).
//      At that edge: gnt<=onehot(winner), busy<=1, ser_frame<=1, state<=SHIFT.
//      Shift register <= {data,cmd} if has_data[winner], else {cmd}.
//      nbits <= CMD_W (+DATA_W if has_data).
//    - SHIFT: ser_data = shreg[0].
//      Bit counter divcnt runs 0..CLK_DIV-1; ser_clk = (divcnt >= CLK_DIV/2).
//      At divcnt==CLK_DIV-1: shift right and decrement nbits.
//      When the last bit ends: done[winner] pulses for 1 cycle; gnt, ser_frame, ser_clk, ser_data <= 0; state<=GAP.
//    - GAP: idle for CLK_DIV cycles (inter-frame separation); then state<=IDLE, busy<=0.
//  - Winner selection:
//    - One requester: it wins.
//    - Both request: the requester != last_gnt wins; last_gnt is updated at grant.
//  - Latency and length:
//    - req seen in IDLE -> gnt and first bit on the next edge.
//    - Frame length = nbits*CLK_DIV cycles.
//    - Minimum req-to-req turnaround = frame + CLK_DIV + 1 cycles.
//  - Inputs are latched at grant:
//    - Changing cmd/data/has_data mid-frame has no effect.
//    - Dropping req mid-frame does not abort; the frame completes and done still pulses.
//  - A requester holding req after done is re-arbitrated.
//    - If both are requesting, the other requester wins (fairness).
//  - req asserted during SHIFT or GAP is ignored until IDLE; no queueing.
//  - Async rst mid-frame: immediate return to reset values; the partial frame is discarded and no done pulse is issued.
// CONFIGURATION
//  ARB_PARITY_EN defined:
//   - One even-parity bit (XOR of all payload bits) is appended after the last payload bit.
//   - nbits is one larger; done pulses after the parity bit.
//  ARB_PARITY_EN undefined:
//   - No parity bit; the frame is exactly CMD_W(+DATA_W) bits.
// TESTING (CLK_DIV=4, CMD_W=DATA_W=8, parity off unless stated)
//  - Reset, then req=01, cmd0=8'h02, has_data=00:
//    gnt=01 next edge; ser_data bits 0,1,0,0,0,0,0,0 each 4 cycles;
//    done=01 at cycle 32; busy low 4 cycles after that.
//  - req=11 held, cmd0=02, cmd1=03:
//    grants alternate 01,10,01; each done pulse is followed by the other grant after GAP+1.
//  - req=10, has_data=10, cmd1=07, data1=8'h05:
//    16-bit frame; ser_data = 1,1,1,0,0,0,0,0 then 1,0,1,0,0,0,0,0; done=10 at cycle 64.
//  - Frame in progress (cmd0=04): change cmd0 to FF and drop req mid-frame:
//    transmitted bits remain 0,0,1,0,0,0,0,0; done still pulses.
//  - rst asserted at cycle 10 of a frame: gnt/busy/ser_* go to 0 immediately;
//    after release with req=11, gnt=01 (last_gnt reset).
//  - ARB_PARITY_EN, cmd0=8'h07, has_data=00:
//    9 bits; 9th bit = 1; done at cycle 36.

Source files
------------

// File: rtl/scanner_link_arbiter_if.sv
// Scanner-side bundle of the shared serial link arbiter: requests, latched payload
// inputs, grant/done handshake and the serial link outputs.
interface scanner_link_arbiter_if #(
  parameter int CMD_W  = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [1:0]        has_data;
  logic [CMD_W-1:0]  cmd0;
  logic [CMD_W-1:0]  cmd1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              busy;
  logic              ser_frame;
  logic              ser_clk;
  logic              ser_data;

  modport master (
    output req, has_data, cmd0, cmd1, data0, data1,
    input  gnt, done, busy, ser_frame, ser_clk, ser_data
  );

  modport slave (
    input  req, has_data, cmd0, cmd1, data0, data1,
    output gnt, done, busy, ser_frame, ser_clk, ser_data
  );
endinterface

// File: rtl/scanner_link_arbiter.sv
// Round-robin arbiter serialising one scanner's cmd(+data) frame LSB-first on a
// gated bit clock. Define ARB_PARITY_EN to append an even-parity bit to each frame.
//   state   | meaning
//   S_IDLE  | waiting for req, arbitrates and latches the winner's payload
//   S_SHIFT | frame bits on ser_data, one bit per CLK_DIV cycles
//   S_GAP   | CLK_DIV cycles of inter-frame separation
module scanner_link_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  scanner_link_arbiter_if.slave  bus
);

`ifdef ARB_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int SH_W  = CMD_W + DATA_W + 1;
  localparam int NB_W  = $clog2(SH_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [NB_W-1:0]  NB_CMD   = NB_W'(CMD_W + PAR);
  localparam logic [NB_W-1:0]  NB_ALL   = NB_W'(CMD_W + DATA_W + PAR);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_last_gnt;
  logic [SH_W-1:0]  r_shreg;
  logic [NB_W-1:0]  r_nbits;
  logic [DIV_W-1:0] r_divcnt;

  logic             w_win;
  logic             w_hasd;
  logic [SH_W-1:0]  w_load;
  logic [NB_W-1:0]  w_nbits;
  logic             w_in_shift;

  // Winner index: a lone requester wins; on a tie the one not granted last time.
  always_comb begin
    w_win = ~bus.req[0];
    if (bus.req == 2'b11) w_win = ~r_last_gnt;
    w_hasd = bus.has_data[w_win];
    w_load = '0;
    w_load[CMD_W-1:0] = w_win ? bus.cmd1 : bus.cmd0;
    if (w_hasd) w_load[CMD_W +: DATA_W] = w_win ? bus.data1 : bus.data0;
`ifdef ARB_PARITY_EN
    w_load[w_hasd ? (CMD_W + DATA_W) : CMD_W] = ^w_load;
`endif
    w_nbits = w_hasd ? NB_ALL : NB_CMD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'b00;
      r_done     <= 2'b00;
      r_last_gnt <= 1'b1;
      r_shreg    <= '0;
      r_nbits    <= '0;
      r_divcnt   <= '0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            r_state    <= S_SHIFT;
            r_gnt      <= {w_win, ~w_win};
            r_last_gnt <= w_win;
            r_shreg    <= w_load;
            r_nbits    <= w_nbits;
            r_divcnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (r_divcnt == DIV_LAST) begin
            r_divcnt <= '0;
            if (r_nbits == NB_W'(1)) begin
              r_done  <= r_gnt;
              r_gnt   <= 2'b00;
              r_state <= S_GAP;
            end else begin
              r_nbits <= r_nbits - NB_W'(1);
              r_shreg <= r_shreg >> 1;
            end
          end else begin
            r_divcnt <= r_divcnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (r_divcnt == DIV_LAST) r_state <= S_IDLE;
          else r_divcnt <= r_divcnt + DIV_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_shift    = (r_state == S_SHIFT);
  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ser_frame = w_in_shift;
  assign bus.ser_clk   = w_in_shift && (r_divcnt >= DIV_HALF);
  assign bus.ser_data  = w_in_shift && r_shreg[0];

endmodule

// File: tb/tb_scanner_link_arbiter.sv
// Bench for scanner_link_arbiter: frame-timeline model checked every cycle, plus
// directed frames whose bit patterns and timings are pinned by literals.
module tb_scanner_link_arbiter;
  localparam int D = 4;
`ifdef ARB_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB8  = 8 + PB;
  localparam int NB16 = 16 + PB;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic chk_on = 1'b0;

  scanner_link_arbiter_if #(.CMD_W(8), .DATA_W(8)) bus();

  scanner_link_arbiter #(.CLK_DIV(D), .CMD_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a bit list plus the number of edges since its grant.
  logic        m_busy;
  logic        m_last;
  logic        m_win;
  int          m_t;
  int          m_n;
  logic [31:0] m_bits;

  function automatic logic pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return !last;
    return (r == 2'b10);
  endfunction

  function automatic int frame_len(input logic w);
    return (bus.has_data[w] ? 16 : 8) + PB;
  endfunction

  function automatic logic [31:0] frame_bits(input logic w);
    logic [31:0] b;
    int n;
    b = {24'd0, (w ? bus.cmd1 : bus.cmd0)};
    n = 8;
    if (bus.has_data[w]) begin
      b[15:8] = w ? bus.data1 : bus.data0;
      n = 16;
    end
    if (PB == 1) b[n] = ^b;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_last <= 1'b1; m_win <= 1'b0;
      m_t <= 0; m_n <= 0; m_bits <= '0;
    end else if (!m_busy) begin
      if (bus.req != 2'b00) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_win  <= pick(bus.req, m_last);
        m_last <= pick(bus.req, m_last);
        m_n    <= frame_len(pick(bus.req, m_last));
        m_bits <= frame_bits(pick(bus.req, m_last));
      end
    end else begin
      if (m_t + 1 == m_n * D + D) m_busy <= 1'b0;
      m_t <= m_t + 1;
    end
  end

  // {gnt, done, busy, ser_frame, ser_clk, ser_data}
  function automatic logic [7:0] model_out();
    logic [7:0] v;
    v = '0;
    if (m_busy) begin
      v[3] = 1'b1;
      if (m_t < m_n * D) begin
        v[7:6] = m_win ? 2'b10 : 2'b01;
        v[2]   = 1'b1;
        v[1]   = ((m_t % D) >= D / 2);
        v[0]   = m_bits[m_t / D];
      end else if (m_t == m_n * D) begin
        v[5:4] = m_win ? 2'b10 : 2'b01;
      end
    end
    return v;
  endfunction

  task automatic check_cycle();
    logic [7:0] e;
    e = model_out();
    check("cyc_gnt",   32'(bus.gnt),       32'(e[7:6]));
    check("cyc_done",  32'(bus.done),      32'(e[5:4]));
    check("cyc_busy",  32'(bus.busy),      32'(e[3]));
    check("cyc_frame", 32'(bus.ser_frame), 32'(e[2]));
    check("cyc_sclk",  32'(bus.ser_clk),   32'(e[1]));
    check("cyc_sdata", 32'(bus.ser_data),  32'(e[0]));
  endtask

  always @(negedge clk) if (!rst && chk_on) check_cycle();

  // Waits for a grant, samples each bit mid-period, then waits for done.
  task automatic run_frame(input int nb, input int drop_k, output logic [31:0] bits,
                           output int t0, output int td, output logic [1:0] g);
    int k;
    bits = '0;
    k = 0;
    while (bus.gnt == 2'b00 && k < 100) begin @(negedge clk); k++; end
    check("grant_seen", 32'(bus.gnt != 2'b00), 32'd1);
    g  = bus.gnt;
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      bits[i] = bus.ser_data;
      if (i == drop_k) begin
        bus.req = 2'b00; bus.has_data = 2'b11;
        bus.cmd0 = 8'hFF; bus.cmd1 = 8'hFF; bus.data0 = 8'hFF; bus.data1 = 8'hFF;
      end
      repeat (D) @(negedge clk);
    end
    k = 0;
    while (bus.done == 2'b00 && k < 10) begin @(negedge clk); k++; end
    check("done_pulse", 32'(bus.done), 32'(g));
    td = cyc;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 200) begin @(negedge clk); k++; end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bits, bits2;
    logic [1:0]  g1, g2, g3;
    int t0, td, t0b, tdb;

    rst = 1'b1;
    bus.req = 2'b00; bus.has_data = 2'b00;
    bus.cmd0 = '0; bus.cmd1 = '0; bus.data0 = '0; bus.data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt",  32'(bus.gnt),  32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ser",  32'({bus.ser_frame, bus.ser_clk, bus.ser_data}), 32'd0);

    // single requester, command only
    bus.req = 2'b01; bus.cmd0 = 8'h02;
    rst = 1'b0;
    chk_on = 1'b1;
    run_frame(NB8, 0, bits, t0, td, g1);
    check("t1_gnt",  32'(g1), 32'h1);
    check("t1_bits", bits, (PB == 1) ? 32'h102 : 32'h002);
    check("t1_done_cycle", 32'(td - t0), 32'(NB8 * D));
    repeat (3) @(negedge clk);
    check("t1_busy_gap", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t1_busy_end", 32'(bus.busy), 32'd0);

    // both requesting from reset: grants alternate 01,10,01
    rst = 1'b1;
    @(negedge clk);
    bus.req = 2'b11; bus.has_data = 2'b00; bus.cmd0 = 8'h02; bus.cmd1 = 8'h03;
    rst = 1'b0;
    run_frame(NB8, -1, bits, t0, td, g1);
    run_frame(NB8, -1, bits2, t0b, tdb, g2);
    check("t2_gnt_a", 32'(g1), 32'h1);
    check("t2_gnt_b", 32'(g2), 32'h2);
    check("t2_bits_a", bits,  (PB == 1) ? 32'h102 : 32'h002);
    check("t2_bits_b", bits2, 32'h003);
    check("t2_turnaround", 32'(t0b - td), 32'(D + 1));
    run_frame(NB8, 0, bits, t0, td, g3);
    check("t2_gnt_c", 32'(g3), 32'h1);
    check("t2_gap_c", 32'(t0 - tdb), 32'(D + 1));
    wait_idle();

    // scanner 1 with data field
    bus.req = 2'b10; bus.has_data = 2'b10; bus.cmd1 = 8'h07; bus.data1 = 8'h05;
    run_frame(NB16, 1, bits, t0, td, g1);
    check("t3_gnt",  32'(g1), 32'h2);
    check("t3_bits", bits, (PB == 1) ? 32'h10507 : 32'h0507);
    check("t3_done_cycle", 32'(td - t0), 32'(NB16 * D));
    wait_idle();

    // mid-frame input changes and req drop do not disturb the frame
    bus.req = 2'b01; bus.has_data = 2'b00; bus.cmd0 = 8'h04;
    run_frame(NB8, 2, bits, t0, td, g1);
    check("t4_bits", bits, (PB == 1) ? 32'h104 : 32'h004);
    check("t4_done_cycle", 32'(td - t0), 32'(NB8 * D));
    wait_idle();

    // async reset mid-frame
    bus.req = 2'b01; bus.has_data = 2'b00; bus.cmd0 = 8'h04;
    @(negedge clk);
    check("t5_grant", 32'(bus.gnt), 32'h1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_gnt",  32'(bus.gnt),  32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_done", 32'(bus.done), 32'd0);
    check("t5_rst_ser",  32'({bus.ser_frame, bus.ser_clk, bus.ser_data}), 32'd0);
    @(negedge clk);
    bus.req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_regrant", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    wait_idle();

    // cmd 07: parity bit set when enabled
    bus.req = 2'b01; bus.has_data = 2'b00; bus.cmd0 = 8'h07;
    run_frame(NB8, 0, bits, t0, td, g1);
    check("t6_bits", bits, (PB == 1) ? 32'h107 : 32'h007);
    check("t6_done_cycle", 32'(td - t0), (PB == 1) ? 32'd36 : 32'd32);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
